mult_share_arbiter_taint: RTL and testbench
===========================================

Name: mult_share_arbiter_taint

Overview:
- Shares one sequential multiplier (control + datapath, with taint tracking) among NREQ requesters using round-robin arbitration.
- Captures the winner's operands and pulses the multiplier's start, then waits for its done signal. Returns the product with requester ID, or a timeout error.
- Every control and data output has a `_t` taint shadow, propagated with the same rules as the multiplier controller: state taint is ORed from any tainted input that steers a transition.

Parameters:
- NREQ, 4, number of requesters (≥2)
- WIDTH, 32, operand width; product is 2*WIDTH
- TIMEOUT, 4*WIDTH+16, max cycles in WAIT before error response

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request, held until granted
- req_t  in  NREQ  taint of req
- op_a  in  NREQ*WIDTH  multiplicand per requester, slice i = requester i
- op_a_t  in  NREQ*WIDTH  taint of op_a
- op_b  in  NREQ*WIDTH  multiplier per requester
- op_b_t  in  NREQ*WIDTH  taint of op_b
- grant  out  NREQ  one-hot acknowledge
- grant_t  out  NREQ  taint of grant
- mult_start  out  1  start pulse to multiplier
- mult_start_t  out  1  taint
- mult_a, mult_b  out  WIDTH  registered operands to multiplier
- mult_a_t, mult_b_t  out  WIDTH  operand taint
- mult_done  in  1  multiplier productDone
- mult_done_t  in  1  taint of mult_done
- mult_product  in  2*WIDTH  multiplier result
- mult_product_t  in  2*WIDTH  result taint
- resp_valid  out  1  one-cycle response strobe
- resp_valid_t  out  1  taint
- resp_id  out  clog2(NREQ)  requester ID of response
- resp_id_t  out  1  taint of resp_id
- resp_err  out  1  timeout flag, valid with resp_valid
- resp_err_t  out  1  taint
- result  out  2*WIDTH  product
- result_t  out  2*WIDTH  product taint

Behaviour:
- Reset: state=IDLE; state_t=0; all outputs and taints 0; owner=0; owner_t=0; rr_ptr=NREQ-1, so requester 0 wins first; timer=0. rst must also reset the multiplier. Reset mid-operation abandons the job and produces no response.
- States are IDLE, ISSUE, WAIT and RESP, with Moore outputs.

IDLE:
- If |req, pick the first asserted requester scanning from rr_ptr+1 with wrap.
- Latch owner, op_a/op_b slices and their taints; go to ISSUE.
- Always: next state_t = state_t | (|req_t). owner_t gets the same value.
- If no req, stay in IDLE.

ISSUE, exactly one cycle:
- grant[owner]=1 and mult_start=1.
- grant_t[owner] and mult_start_t equal |state_t.
- timer cleared; go to WAIT.

WAIT:
- mult_a/mult_b stay stable; the multiplier loads them one cycle after start.
- If mult_done: latch mult_product into result, mult_product_t into result_t, resp_err=0; go to RESP.
- Else if timer==TIMEOUT-1: result=0, result_t=0, resp_err=1; go to RESP.
- Else timer++.
- Each WAIT cycle: state_t |= mult_done_t.

RESP, exactly one cycle:
- resp_valid=1; resp_id=owner; resp_err as latched.
- resp_valid_t and resp_err_t equal |state_t; resp_id_t=owner_t.
- rr_ptr<=owner; go to IDLE with state_t<=0, because the transition is unconditional.

Other rules:
- Latency from req sampled in IDLE: grant at +1, start at +1, response 1 cycle after the done cycle.
- mult_done seen in IDLE, ISSUE or RESP is ignored.
- req dropped before grant means that requester is simply not picked. req still high after grant means it is eligible again in the next IDLE.
- grant is one-hot or zero. At most one job is outstanding.
- No arithmetic on operands; widths pass through unchanged.

Decomposition:
- Package mult_share_pkg holds:
  - state encoding localparams (IDLE=0, ISSUE=1, WAIT=2, RESP=3, STATE_W=2)
  - ID_W=$clog2(NREQ)
  - a timer-width function
- One combinational sub-module, rr_pick (inputs req and ptr; outputs winner ID and valid), reused by other arbiters in the design.

Test Plan:
- Single request: req=0001, op_a[0]=7, op_b[0]=6, multiplier done after N cycles → grant=0001 at +1, one mult_start pulse, resp_valid with resp_id=0, result=42, resp_err=0, all taints 0.
- Contention: req=1111 held for four jobs from reset → grant order 0,1,2,3. Then req=1001 with rr_ptr=3 → requester 0 granted next.
- Taint on request: req=0010, req_t=0100 → grant_t[1]=1, mult_start_t=1, resp_valid_t=1, resp_id_t=1. Next job with clean inputs → all control taints 0.
- Data taint: op_a_t[0]=all ones, op_b_t=0 → mult_a_t=all ones. result_t equals mult_product_t as driven; resp_valid_t=0.
- Timeout: mult_done held 0 → exactly TIMEOUT WAIT cycles, then resp_valid=1, resp_err=1, result=0. Arbiter returns to IDLE and serves the next req.
- Reset mid-WAIT: assert rst for one cycle → no resp_valid, all outputs 0, state_t=0. Next req=0001 is granted normally.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: state encoding and
// width helpers for requester IDs and the WAIT timeout counter.
package mult_share_pkg;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ISSUE = 2'd1;
  localparam logic [STATE_W-1:0] WAIT  = 2'd2;
  localparam logic [STATE_W-1:0] RESP  = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = IDLE,
    S_ISSUE = ISSUE,
    S_WAIT  = WAIT,
    S_RESP  = RESP
  } state_e;

  localparam int NREQ_DEF = 4;
  localparam int ID_W     = $clog2(NREQ_DEF);

  // Never narrower than one bit, so NREQ=2 and tiny timeouts still work.
  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int timer_w(input int t);
    return (t > 2) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_taint_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning upward
// from ptr+1 with wrap-around.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  idx,
  output logic            vld
);

  // Scan the farthest offset first so the nearest request overwrites it.
  always_comb begin
    idx = '0;
    vld = |req;
    for (int off = NREQ; off >= 1; off--) begin
      if (req[(int'(ptr) + off) % NREQ]) idx = IDW'((int'(ptr) + off) % NREQ);
    end
  end

endmodule

// File: rtl/mult_share_arbiter_taint.sv
// Round-robin front end sharing one sequential multiplier among NREQ
// requesters, with a taint shadow on every control and data output.
module mult_share_arbiter_taint
  import mult_share_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 4*WIDTH+16,
  localparam int IDW    = (NREQ == NREQ_DEF) ? ID_W : id_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_t,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_a_t,
  input  logic [NREQ*WIDTH-1:0] op_b,
  input  logic [NREQ*WIDTH-1:0] op_b_t,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       grant_t,
  output logic                  mult_start,
  output logic                  mult_start_t,
  output logic [WIDTH-1:0]      mult_a,
  output logic [WIDTH-1:0]      mult_b,
  output logic [WIDTH-1:0]      mult_a_t,
  output logic [WIDTH-1:0]      mult_b_t,
  input  logic                  mult_done,
  input  logic                  mult_done_t,
  input  logic [2*WIDTH-1:0]    mult_product,
  input  logic [2*WIDTH-1:0]    mult_product_t,
  output logic                  resp_valid,
  output logic                  resp_valid_t,
  output logic [IDW-1:0]        resp_id,
  output logic                  resp_id_t,
  output logic                  resp_err,
  output logic                  resp_err_t,
  output logic [2*WIDTH-1:0]    result,
  output logic [2*WIDTH-1:0]    result_t
);

  localparam int TW = timer_w(TIMEOUT);

  state_e               state_q, state_d;
  logic                 state_t_q, state_t_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic                 owner_t_q, owner_t_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [WIDTH-1:0]     mult_a_q, mult_a_d, mult_a_t_q, mult_a_t_d;
  logic [WIDTH-1:0]     mult_b_q, mult_b_d, mult_b_t_q, mult_b_t_d;
  logic [2*WIDTH-1:0]   result_q, result_d, result_t_q, result_t_d;
  logic                 err_q, err_d;
  logic [IDW-1:0]       pick_id;
  logic                 pick_vld;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .idx (pick_id),
    .vld (pick_vld)
  );

  always_comb begin
    state_d    = state_q;
    state_t_d  = state_t_q;
    owner_d    = owner_q;
    owner_t_d  = owner_t_q;
    rr_ptr_d   = rr_ptr_q;
    timer_d    = timer_q;
    mult_a_d   = mult_a_q;
    mult_a_t_d = mult_a_t_q;
    mult_b_d   = mult_b_q;
    mult_b_t_d = mult_b_t_q;
    result_d   = result_q;
    result_t_d = result_t_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        // req steers the IDLE exit, so its taint lands in state even when idle.
        state_t_d = state_t_q | (|req_t);
        owner_t_d = state_t_q | (|req_t);
        if (pick_vld) begin
          owner_d    = pick_id;
          mult_a_d   = op_a[int'(pick_id)*WIDTH +: WIDTH];
          mult_a_t_d = op_a_t[int'(pick_id)*WIDTH +: WIDTH];
          mult_b_d   = op_b[int'(pick_id)*WIDTH +: WIDTH];
          mult_b_t_d = op_b_t[int'(pick_id)*WIDTH +: WIDTH];
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        state_t_d = state_t_q | mult_done_t;
        if (mult_done) begin
          result_d   = mult_product;
          result_t_d = mult_product_t;
          err_d      = 1'b0;
          state_d    = S_RESP;
        end else if (timer_q == TW'(TIMEOUT-1)) begin
          result_d   = '0;
          result_t_d = '0;
          err_d      = 1'b1;
          state_d    = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        rr_ptr_d  = owner_q;
        state_t_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      state_t_q  <= 1'b0;
      owner_q    <= '0;
      owner_t_q  <= 1'b0;
      rr_ptr_q   <= IDW'(NREQ-1);
      timer_q    <= '0;
      mult_a_q   <= '0;
      mult_a_t_q <= '0;
      mult_b_q   <= '0;
      mult_b_t_q <= '0;
      result_q   <= '0;
      result_t_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      state_t_q  <= state_t_d;
      owner_q    <= owner_d;
      owner_t_q  <= owner_t_d;
      rr_ptr_q   <= rr_ptr_d;
      timer_q    <= timer_d;
      mult_a_q   <= mult_a_d;
      mult_a_t_q <= mult_a_t_d;
      mult_b_q   <= mult_b_d;
      mult_b_t_q <= mult_b_t_d;
      result_q   <= result_d;
      result_t_q <= result_t_d;
      err_q      <= err_d;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    grant   = '0;
    grant_t = '0;
    if (state_q == S_ISSUE) begin
      grant[owner_q]   = 1'b1;
      grant_t[owner_q] = state_t_q;
    end
  end

  assign mult_start   = (state_q == S_ISSUE);
  assign mult_start_t = (state_q == S_ISSUE) & state_t_q;
  assign mult_a       = mult_a_q;
  assign mult_a_t     = mult_a_t_q;
  assign mult_b       = mult_b_q;
  assign mult_b_t     = mult_b_t_q;
  assign resp_valid   = (state_q == S_RESP);
  assign resp_valid_t = (state_q == S_RESP) & state_t_q;
  assign resp_id      = (state_q == S_RESP) ? owner_q : '0;
  assign resp_id_t    = (state_q == S_RESP) & owner_t_q;
  assign resp_err     = (state_q == S_RESP) & err_q;
  assign resp_err_t   = (state_q == S_RESP) & state_t_q;
  assign result       = result_q;
  assign result_t     = result_t_q;

endmodule

// File: tb/tb_mult_share_arbiter_taint.sv
// Randomized bench for mult_share_arbiter_taint; the bench plays the shared
// multiplier and predicts grants, responses and taints from a job-level model.
module tb_mult_share_arbiter_taint;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int TO   = 4*W+16;
  localparam int IDW  = 2;

  logic                 clk, rst;
  logic [NREQ-1:0]      req, req_t;
  logic [NREQ*W-1:0]    op_a, op_a_t, op_b, op_b_t;
  logic [NREQ-1:0]      grant, grant_t;
  logic                 mult_start, mult_start_t;
  logic [W-1:0]         mult_a, mult_b, mult_a_t, mult_b_t;
  logic                 mult_done, mult_done_t;
  logic [2*W-1:0]       mult_product, mult_product_t;
  logic                 resp_valid, resp_valid_t, resp_id_t, resp_err, resp_err_t;
  logic [IDW-1:0]       resp_id;
  logic [2*W-1:0]       result, result_t;

  mult_share_arbiter_taint #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_t(req_t),
    .op_a(op_a), .op_a_t(op_a_t), .op_b(op_b), .op_b_t(op_b_t),
    .grant(grant), .grant_t(grant_t),
    .mult_start(mult_start), .mult_start_t(mult_start_t),
    .mult_a(mult_a), .mult_b(mult_b), .mult_a_t(mult_a_t), .mult_b_t(mult_b_t),
    .mult_done(mult_done), .mult_done_t(mult_done_t),
    .mult_product(mult_product), .mult_product_t(mult_product_t),
    .resp_valid(resp_valid), .resp_valid_t(resp_valid_t),
    .resp_id(resp_id), .resp_id_t(resp_id_t),
    .resp_err(resp_err), .resp_err_t(resp_err_t),
    .result(result), .result_t(result_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ptr_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first requester after the last served one, wrapping.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int off = 1; off <= NREQ; off++)
      if (r[(p + off) % NREQ]) return (p + off) % NREQ;
    return -1;
  endfunction

  task automatic rand_ops(input bit taint_en);
    for (int i = 0; i < NREQ; i++) begin
      op_a[i*W +: W]   = W'($urandom);
      op_b[i*W +: W]   = W'($urandom);
      op_a_t[i*W +: W] = taint_en ? W'($urandom) : '0;
      op_b_t[i*W +: W] = taint_en ? W'($urandom) : '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    ptr_m = NREQ - 1;
  endtask

  // One complete job from an IDLE cycle: request, issue, multiply, response.
  task automatic job(input logic [NREQ-1:0] r, input logic [NREQ-1:0] rt, input int dly,
                     input bit to, input logic [2*W-1:0] pt, input bit dt);
    int w;
    int n;
    bit st;
    logic [W-1:0]   a, b, at, bt;
    logic [2*W-1:0] prod;
    w  = pick(r, ptr_m);
    st = |rt;
    a  = op_a[w*W +: W];
    b  = op_b[w*W +: W];
    at = op_a_t[w*W +: W];
    bt = op_b_t[w*W +: W];
    prod = (2*W)'(a) * (2*W)'(b);
    req = r;
    req_t = rt;
    step();
    req = '0;
    req_t = '0;
    chk("grant", grant, 64'(1) << w);
    chk("grant_t", grant_t, st ? (64'(1) << w) : 64'(0));
    chk("mult_start", mult_start, 1);
    chk("mult_start_t", mult_start_t, st);
    chk("mult_a", mult_a, a);
    chk("mult_b", mult_b, b);
    chk("mult_a_t", mult_a_t, at);
    chk("mult_b_t", mult_b_t, bt);
    step();
    chk("start_pulse_len", {grant, mult_start}, 0);
    if (!to) begin
      repeat (dly) step();
      chk("no_early_resp", resp_valid, 0);
      mult_done = 1'b1;
      mult_done_t = dt;
      mult_product = prod;
      mult_product_t = pt;
      step();
      mult_done = 1'b0;
      mult_done_t = 1'b0;
      mult_product = (2*W)'($urandom);
      mult_product_t = '0;
      chk("resp_valid", resp_valid, 1);
      chk("resp_id", resp_id, w);
      chk("resp_err", resp_err, 0);
      chk("result", result, prod);
      chk("result_t", result_t, pt);
      chk("resp_valid_t", resp_valid_t, st | dt);
      chk("resp_err_t", resp_err_t, st | dt);
      chk("resp_id_t", resp_id_t, st);
    end else begin
      n = 0;
      while (!resp_valid && n < TO + 8) begin
        step();
        n++;
      end
      chk("timeout_cycles", n, TO);
      chk("to_resp_valid", resp_valid, 1);
      chk("to_resp_err", resp_err, 1);
      chk("to_resp_id", resp_id, w);
      chk("to_result", result, 0);
      chk("to_result_t", result_t, 0);
      chk("to_resp_valid_t", resp_valid_t, st);
    end
    ptr_m = w;
    step();
    chk("resp_one_cycle", resp_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    req = '0; req_t = '0;
    op_a = '0; op_a_t = '0; op_b = '0; op_b_t = '0;
    mult_done = 1'b0; mult_done_t = 1'b0;
    mult_product = '0; mult_product_t = '0;
    do_reset();

    chk("rst_grant", {grant, grant_t, mult_start, mult_start_t}, 0);
    chk("rst_resp", {resp_valid, resp_valid_t, resp_id, resp_id_t, resp_err, resp_err_t}, 0);
    chk("rst_mult_ops", {mult_a, mult_b, mult_a_t, mult_b_t}, 0);
    chk("rst_result", {result, result_t}, 0);

    // A done strobe with no job outstanding must be ignored.
    mult_done = 1'b1;
    step();
    mult_done = 1'b0;
    step();
    chk("idle_done_ignored", {resp_valid, mult_start}, 0);

    // Single request, 7*6.
    rand_ops(0);
    op_a[0 +: W] = 8'd7;
    op_b[0 +: W] = 8'd6;
    job(4'b0001, 4'b0000, 3, 0, '0, 0);

    // Contention from reset: 0,1,2,3 then 1001 wraps to 0.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      rand_ops(0);
      chk("rr_order", pick(4'b1111, ptr_m), k);
      job(4'b1111, 4'b0000, k, 0, '0, 0);
    end
    chk("rr_wrap", pick(4'b1001, ptr_m), 0);
    job(4'b1001, 4'b0000, 1, 0, '0, 0);

    // Control taint from req_t, then a clean job clears it.
    rand_ops(0);
    job(4'b0010, 4'b0100, 2, 0, '0, 0);
    rand_ops(0);
    job(4'b0010, 4'b0000, 2, 0, '0, 0);

    // Data taint passes through without touching control taint.
    rand_ops(0);
    op_a_t[0 +: W] = '1;
    job(4'b0001, 4'b0000, 2, 0, 16'hA5C3, 0);

    // Timeout, then the next request is served normally.
    rand_ops(0);
    job(4'b0100, 4'b0000, 0, 1, '0, 0);
    rand_ops(1);
    job(4'b1000, 4'b0000, 4, 0, 16'h0F0F, 1);

    for (int it = 0; it < 24; it++) begin
      rand_ops(($urandom % 2) == 1);
      job(4'($urandom_range(1, 15)), (($urandom % 4) == 0) ? 4'($urandom) : 4'b0000,
          $urandom_range(0, 12), ($urandom % 8) == 0, 16'($urandom), ($urandom % 4) == 0);
    end

    // Reset in the middle of WAIT abandons the job silently.
    rand_ops(0);
    req = 4'b0001;
    step();
    req = '0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ptr_m = NREQ - 1;
    chk("midrst_ctrl", {grant, grant_t, mult_start, mult_start_t, resp_valid, resp_valid_t}, 0);
    chk("midrst_data", {mult_a, mult_b, mult_a_t, mult_b_t, result, result_t}, 0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (TO + 4) begin
        step();
        seen = seen | resp_valid | mult_start;
      end
      chk("midrst_no_resp", seen, 0);
    end
    rand_ops(0);
    job(4'b0001, 4'b0000, 2, 0, '0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
